// File: rtl/u_ins_loader_if.sv
// Byte-in / instruction-write bundle between the boot loader and its byte source
// and instruction memory. slave = loader side, master = source/memory side.
interface u_ins_loader_if #(
  parameter int unsigned CNT_W = 9
);
  logic             i_u_ins_loader_start;
  logic [CNT_W-1:0] i_u_ins_loader_num_words;
  logic [7:0]       i_u_ins_loader_byte;
  logic             i_u_ins_loader_byte_valid;
  logic             o_u_ins_loader_byte_ready;
  logic [31:0]      o_u_ins_loader_wr_ins;
  logic             o_u_ins_loader_wr_en;
  logic             o_u_ins_loader_cpu_reset;
  logic             o_u_ins_loader_done;
  logic [31:0]      o_u_ins_loader_checksum;

  modport slave (
    input  i_u_ins_loader_start,
    input  i_u_ins_loader_num_words,
    input  i_u_ins_loader_byte,
    input  i_u_ins_loader_byte_valid,
    output o_u_ins_loader_byte_ready,
    output o_u_ins_loader_wr_ins,
    output o_u_ins_loader_wr_en,
    output o_u_ins_loader_cpu_reset,
    output o_u_ins_loader_done,
    output o_u_ins_loader_checksum
  );

  modport master (
    output i_u_ins_loader_start,
    output i_u_ins_loader_num_words,
    output i_u_ins_loader_byte,
    output i_u_ins_loader_byte_valid,
    input  o_u_ins_loader_byte_ready,
    input  o_u_ins_loader_wr_ins,
    input  o_u_ins_loader_wr_en,
    input  o_u_ins_loader_cpu_reset,
    input  o_u_ins_loader_done,
    input  o_u_ins_loader_checksum
  );
endinterface

// File: rtl/u_ins_loader.sv
// Boot loader: packs little-endian bytes into 32-bit words, strobes them into
// instruction memory and holds the CPU in reset until the last word is written.
module u_ins_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 9
) (
  input  logic            i_sys_clock,
  input  logic            i_sys_reset,
  u_ins_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [1:0]       byte_cnt_q;
  logic [23:0]      asm_q;
  logic             byte_ready_q;
  logic [31:0]      wr_ins_q;
  logic             wr_en_q;
  logic             cpu_reset_q;
  logic             done_q;
  logic [31:0]      checksum_q;

  logic [CNT_W-1:0] clamped_c;
  logic [CNT_W-1:0] word_cnt_inc_c;
  logic             accept_c;

  assign clamped_c = (bus.i_u_ins_loader_num_words > CNT_W'(MAX_WORDS))
                   ? CNT_W'(MAX_WORDS) : bus.i_u_ins_loader_num_words;
  assign word_cnt_inc_c = word_cnt_q + CNT_W'(1);
  assign accept_c       = byte_ready_q & bus.i_u_ins_loader_byte_valid;

  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      wr_ins_q     <= '0;
      wr_en_q      <= 1'b0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      checksum_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.i_u_ins_loader_start) begin
            count_q    <= clamped_c;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            checksum_q <= '0;
            if (clamped_c == '0) begin
              state_q     <= S_DONE;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q      <= S_RECV;
              byte_ready_q <= 1'b1;
              cpu_reset_q  <= 1'b1;
              done_q       <= 1'b0;
            end
          end
        end
        S_RECV: begin
          if (accept_c) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: asm_q[7:0]   <= bus.i_u_ins_loader_byte;
              2'd1: asm_q[15:8]  <= bus.i_u_ins_loader_byte;
              2'd2: asm_q[23:16] <= bus.i_u_ins_loader_byte;
              default: begin
                // Fourth byte lands straight in the output word; strobe next cycle.
                wr_ins_q     <= {bus.i_u_ins_loader_byte, asm_q};
                wr_en_q      <= 1'b1;
                byte_ready_q <= 1'b0;
                state_q      <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          checksum_q <= checksum_q ^ wr_ins_q;
          word_cnt_q <= word_cnt_inc_c;
          if (word_cnt_inc_c == count_q) begin
            state_q     <= S_DONE;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            state_q      <= S_RECV;
            byte_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_u_ins_loader_byte_ready = byte_ready_q;
  assign bus.o_u_ins_loader_wr_ins     = wr_ins_q;
  assign bus.o_u_ins_loader_wr_en      = wr_en_q;
  assign bus.o_u_ins_loader_cpu_reset  = cpu_reset_q;
  assign bus.o_u_ins_loader_done       = done_q;
  assign bus.o_u_ins_loader_checksum   = checksum_q;

endmodule
